// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one sync-read memory between a pipeline port and a starvation-guarded GPIO readout stream
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_gnt,
  output logic              pipe_stall,
  output logic              pipe_rvalid,
  output logic [DATA_W-1:0] pipe_rdata,
  input  logic              stream_start,
  input  logic [ADDR_W-1:0] stream_base,
  input  logic [ADDR_W-1:0] stream_len,
  output logic              stream_busy,
  output logic              stream_done,
  output logic [DATA_W-1:0] gpio_data,
  output logic              gpio_valid,
  input  logic              gpio_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q, rem_q;
  logic [SW-1:0] starve;
  logic stream_gnt, rvalid_q, gvalid_q;
  logic [DATA_W-1:0] rdata_q, gdata_q;
  // Outputs are gated by rst so reset wins even before the clock edge lands
  always_comb begin
    stream_gnt = ~rst & (state == ISSUE) & (~pipe_req | (starve == SMAX));
    pipe_gnt = ~rst & pipe_req & ~stream_gnt;
    pipe_stall = pipe_req & ~pipe_gnt;
    mem_en = pipe_gnt | stream_gnt;
    mem_we = pipe_gnt & pipe_we;
    mem_addr = pipe_gnt ? pipe_addr : stream_gnt ? addr_q : '0;
    mem_wdata = pipe_gnt ? pipe_wdata : '0;
    pipe_rvalid = ~rst & rvalid_q;
    pipe_rdata = rst ? '0 : rvalid_q ? mem_rdata : rdata_q;
    gpio_valid = ~rst & gvalid_q;
    gpio_data = rst ? '0 : gdata_q;
    stream_busy = ~rst & (state inside {ISSUE, WAIT, DRAIN});
    stream_done = ~rst & (state == DONE);
    state_n = state;
    case (state)
      IDLE:    state_n = stream_start ? ((stream_len == '0) ? DONE : ISSUE) : IDLE;
      ISSUE:   state_n = stream_gnt ? WAIT : ISSUE;
      WAIT:    state_n = DRAIN;
      DRAIN:   state_n = (gvalid_q & gpio_ready) ? ((rem_q != '0) ? ISSUE : DONE) : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      starve <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      gdata_q <= '0;
      gvalid_q <= 1'b0;
    end else begin
      state <= state_n;
      rvalid_q <= pipe_gnt & ~pipe_we;
      if (rvalid_q) rdata_q <= mem_rdata;
      starve <= (state != ISSUE || stream_gnt) ? '0 : (pipe_gnt && starve != SMAX) ? starve + SW'(1) : starve;
      if (state == IDLE && stream_start) begin
        addr_q <= stream_base;
        rem_q <= stream_len;
      end
      if (stream_gnt) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q <= rem_q - ADDR_W'(1);
      end
      if (state == WAIT) begin
        gdata_q <= mem_rdata;
        gvalid_q <= 1'b1;
      end
      if (state == DRAIN && gvalid_q && gpio_ready) gvalid_q <= 1'b0;
    end
  end
endmodule
